// File: rtl/life_board_top.sv
// rtl/life_board_top.sv - 8x8 Game of Life on a 16x16 red/green LED matrix (optional macro CURSOR_WRAP_EN)
module life_board_top #(
  parameter int GEN_LOG2  = 24,
  parameter int SCAN_LOG2 = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   KEY,
  input  logic         SW_pause,
  input  logic         SW_activate,
  output logic [255:0] RedPixels,
  output logic [255:0] GrnPixels,
  output logic [35:0]  GPIO_1
);

  localparam logic [31:0] GEN_MASK  = (32'd1 << GEN_LOG2) - 32'd1;
  localparam logic [31:0] SCAN_MASK = (32'd1 << SCAN_LOG2) - 32'd1;

  logic [31:0] r_div;
  logic [3:0]  r_key_s1, r_key_s2, r_key_d;
  logic [3:0]  r_cur_x, r_cur_y;
  logic [63:0] r_cells;
  logic [3:0]  r_row;
  logic [35:0] r_gpio;

  logic [3:0]  w_press;
  logic        w_right, w_up, w_down, w_left;
  logic [3:0]  w_x_next, w_y_next;
  logic        w_gen_tick, w_scan_tick;
  logic [2:0]  w_cx, w_cy;
  logic [5:0]  w_cur_idx;
  logic [63:0] w_evolved;
  logic [63:0] w_cells_next;
  logic [3:0]  w_row_next;

  // Cell (y,x) of the playfield; anything outside 1..8 reads as dead.
  function automatic logic cell_at(input logic [63:0] c, input int y, input int x);
    if (y < 1 || y > 8 || x < 1 || x > 8) return 1'b0;
    return c[(y - 1) * 8 + (x - 1)];
  endfunction

  assign w_gen_tick  = ((r_div & GEN_MASK) == 32'd0);
  assign w_scan_tick = ((r_div & SCAN_MASK) == 32'd0);

  // Free-running divider paces generations and row scanning.
  always_ff @(posedge CLK) begin
    if (RST) r_div <= 32'd0;
    else     r_div <= r_div + 32'd1;
  end

  // Two-flop synchronizer plus one delay stage for press detection; idle level is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
      r_key_d  <= 4'hF;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
    end
  end

  // One-cycle pulse on the synchronized high-to-low transition only.
  assign w_press = r_key_d & ~r_key_s2;
  assign w_right = w_press[0];
  assign w_up    = w_press[1];
  assign w_down  = w_press[2];
  assign w_left  = w_press[3];

  // Per-axis cursor step; opposing presses cancel, edges clamp or wrap.
  always_comb begin
    w_x_next = r_cur_x;
    w_y_next = r_cur_y;
    if (w_right && !w_left) begin
      if (r_cur_x != 4'd8) w_x_next = r_cur_x + 4'd1;
`ifdef CURSOR_WRAP_EN
      else                 w_x_next = 4'd1;
`endif
    end else if (w_left && !w_right) begin
      if (r_cur_x != 4'd1) w_x_next = r_cur_x - 4'd1;
`ifdef CURSOR_WRAP_EN
      else                 w_x_next = 4'd8;
`endif
    end
    if (w_down && !w_up) begin
      if (r_cur_y != 4'd8) w_y_next = r_cur_y + 4'd1;
`ifdef CURSOR_WRAP_EN
      else                 w_y_next = 4'd1;
`endif
    end else if (w_up && !w_down) begin
      if (r_cur_y != 4'd1) w_y_next = r_cur_y - 4'd1;
`ifdef CURSOR_WRAP_EN
      else                 w_y_next = 4'd8;
`endif
    end
  end

  // Cursor position register, starting at the bottom-right cell.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cur_x <= 4'd8;
      r_cur_y <= 4'd8;
    end else begin
      r_cur_x <= w_x_next;
      r_cur_y <= w_y_next;
    end
  end

  // 3-bit subtract maps coordinate 8 to index 7 without needing the top bit.
  assign w_cx      = r_cur_x[2:0] - 3'd1;
  assign w_cy      = r_cur_y[2:0] - 3'd1;
  assign w_cur_idx = {w_cy, w_cx};

  // B3/S23 rule for every cell from a 4-bit neighbour count.
  always_comb begin
    logic [3:0] cnt;
    w_evolved = '0;
    cnt       = 4'd0;
    for (int y = 1; y <= 8; y++) begin
      for (int x = 1; x <= 8; x++) begin
        cnt = 4'd0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy != 0 || dx != 0) cnt = cnt + {3'b000, cell_at(r_cells, y + dy, x + dx)};
          end
        end
        w_evolved[(y - 1) * 8 + (x - 1)] = (cnt == 4'd3) ||
                                           (cell_at(r_cells, y, x) && cnt == 4'd2);
      end
    end
  end

  // Evolution on an unpaused tick, then activation wins for the cursor cell.
  always_comb begin
    w_cells_next = r_cells;
    if (w_gen_tick && !SW_pause) w_cells_next = w_evolved;
    if (SW_activate)             w_cells_next[w_cur_idx] = 1'b1;
  end

  // Cell state registers.
  always_ff @(posedge CLK) begin
    if (RST) r_cells <= '0;
    else     r_cells <= w_cells_next;
  end

  // Map cursor and cells onto the 16x16 frame; border rows/columns stay dark.
  always_comb begin
    RedPixels = '0;
    GrnPixels = '0;
    RedPixels[{r_cur_y, r_cur_x}] = 1'b1;
    for (int y = 1; y <= 8; y++) begin
      for (int x = 1; x <= 8; x++) begin
        GrnPixels[y * 16 + x] = r_cells[(y - 1) * 8 + (x - 1)];
      end
    end
  end

  assign w_row_next = w_scan_tick ? r_row + 4'd1 : r_row;

  // Row scanner: the drive word is captured together with the row it belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_row  <= 4'd0;
      r_gpio <= '0;
    end else begin
      r_row  <= w_row_next;
      r_gpio <= {w_row_next,
                 GrnPixels[{w_row_next, 4'b0000} +: 16],
                 RedPixels[{w_row_next, 4'b0000} +: 16]};
    end
  end

  assign GPIO_1 = r_gpio;

endmodule

// File: tb/tb_life_board_top.sv
// tb/tb_life_board_top.sv - directed self-checking bench for life_board_top
module tb_life_board_top;

  logic         CLK;
  logic         RST;
  logic [3:0]   KEY;
  logic         SW_pause;
  logic         SW_activate;
  logic [255:0] RedPixels;
  logic [255:0] GrnPixels;
  logic [35:0]  GPIO_1;

  int checks = 0;
  int errors = 0;
  int n_edge = 0;

  life_board_top #(.GEN_LOG2(2), .SCAN_LOG2(0)) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .SW_pause(SW_pause), .SW_activate(SW_activate),
    .RedPixels(RedPixels), .GrnPixels(GrnPixels), .GPIO_1(GPIO_1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [255:0] pix(input int y, input int x);
    logic [255:0] one;
    one = 256'd1;
    return one << (y * 16 + x);
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clock edges; n_edge counts edges taken out of reset, which equals the divider value.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      if (!RST) n_edge++;
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    step(n);
    RST = 1'b0;
    n_edge = 0;
  endtask

  task automatic press(input logic [3:0] mask);
    KEY = ~mask;
    step(2);
    KEY = 4'hF;
    step(2);
  endtask

  task automatic plant();
    SW_activate = 1'b1;
    step(1);
    SW_activate = 1'b0;
  endtask

  // Exactly one unpaused generation tick.
  task automatic gen_step();
    while (n_edge % 4 != 0) step(1);
    SW_pause = 1'b0;
    step(1);
    SW_pause = 1'b1;
  endtask

  initial begin
    logic [255:0] exp_red, exp_grn;
    int r;
    KEY = 4'hF;
    SW_pause = 1'b1;
    SW_activate = 1'b0;

    RST = 1'b1;
    step(2);
    check("rst_red",  RedPixels, pix(8, 8));
    check("rst_grn",  GrnPixels, '0);
    check("rst_gpio", {220'd0, GPIO_1}, '0);
    check("rst_div",  {224'd0, dut.r_div}, '0);
    RST = 1'b0;
    n_edge = 0;

    press(4'b0001);
    press(4'b0001);
`ifdef CURSOR_WRAP_EN
    check("right_edge", RedPixels, pix(8, 2));
`else
    check("right_edge", RedPixels, pix(8, 8));
`endif

    do_reset(2);
    KEY = 4'b0111;
    step(2);
    check("key_lat_e1", RedPixels, pix(8, 8));
    step(1);
    check("key_lat_e2", RedPixels, pix(8, 7));
    step(6);
    KEY = 4'hF;
    step(3);
    check("key_hold", RedPixels, pix(8, 7));
    press(4'b1000);
    press(4'b0010);
    press(4'b0010);
    press(4'b0100);
    check("cursor_7_6", RedPixels, pix(7, 6));
    press(4'b0110);
    check("cancel_ud", RedPixels, pix(7, 6));
    press(4'b1001);
    check("cancel_lr", RedPixels, pix(7, 6));

    do_reset(2);
    for (int i = 0; i < 4; i++) press(4'b0010);
    for (int i = 0; i < 5; i++) press(4'b1000);
    check("cursor_4_3", RedPixels, pix(4, 3));
    plant();
    check("plant_1", GrnPixels, pix(4, 3));
    press(4'b0001);
    plant();
    press(4'b0001);
    plant();
    step(6);
    check("plant_3", GrnPixels, pix(4, 3) | pix(4, 4) | pix(4, 5));
    gen_step();
    check("blink_v", GrnPixels, pix(3, 4) | pix(4, 4) | pix(5, 4));
    gen_step();
    check("blink_h", GrnPixels, pix(4, 3) | pix(4, 4) | pix(4, 5));

    do_reset(2);
    plant();
    check("single_set", GrnPixels, pix(8, 8));
    gen_step();
    check("single_dies", GrnPixels, '0);
    SW_activate = 1'b1;
    SW_pause = 1'b0;
    step(9);
    check("single_held", GrnPixels, pix(8, 8));
    SW_activate = 1'b0;
    SW_pause = 1'b1;
    step(4);
    check("act_off_keeps", GrnPixels, pix(8, 8));

    exp_red = pix(8, 8);
    exp_grn = pix(8, 8);
    for (int i = 0; i < 20; i++) begin
      step(1);
      r = n_edge % 16;
      check("scan_row", {252'd0, GPIO_1[35:32]}, 256'(r));
      check("scan_grn", {240'd0, GPIO_1[31:16]}, {240'd0, exp_grn[r * 16 +: 16]});
      check("scan_red", {240'd0, GPIO_1[15:0]},  {240'd0, exp_red[r * 16 +: 16]});
    end

    press(4'b1000);
    RST = 1'b1;
    step(1);
    check("midrst_red",  RedPixels, pix(8, 8));
    check("midrst_grn",  GrnPixels, '0);
    check("midrst_gpio", {220'd0, GPIO_1}, '0);
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
